// File: rtl/game_pkg.sv
// Shared types and sizing helpers for the key matrix scanner and the LED column driver.
package game_pkg;

  typedef enum logic [1:0] {IDLE, PRESSED, MULTI} scan_state_t;

  localparam int DEF_COLS = 4;
  localparam int DEF_ROWS = 4;

  // Width of a linear key code row*COLS+col; never narrower than one bit.
  function automatic int code_w(input int rows, input int cols);
    return (rows * cols > 2) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/key_matrix_scanner_if.sv
// Matrix pins plus the key event bus toward the game state-transition logic.
interface key_matrix_scanner_if
  import game_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
);
  localparam int KW = code_w(ROWS, COLS);

  logic [COLS-1:0] col_drive;
  logic [ROWS-1:0] row_in;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;
  logic            multi_key;

  modport master (
    output col_drive, key_code, key_valid, key_held, multi_key,
    input  row_in
  );

  modport slave (
    input  col_drive, key_code, key_valid, key_held, multi_key,
    output row_in
  );
endinterface

// File: rtl/scan_col_timer.sv
// Column dwell counter and one-hot active-low strobe shared by matrix scan and LED drive.
module scan_col_timer #(
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 100_000
)(
  input  logic                    clk,
  input  logic                    reset,
  output logic [$clog2(COLS)-1:0] col_idx,
  output logic [COLS-1:0]         col_drive,
  output logic                    sample_strobe,
  output logic                    frame_end
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(COLS);
  localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] LAST_COL = IW'(COLS - 1);

  logic [CW-1:0] cnt;

  assign sample_strobe = (cnt == LAST_CNT);
  assign frame_end     = sample_strobe && (col_idx == LAST_COL);

  // col_drive follows col_idx one cycle late, so a fresh column settles
  // well before its sample at the end of the dwell.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      col_idx   <= '0;
      col_drive <= ~COLS'(1);
    end else begin
      col_drive <= ~(COLS'(1) << col_idx);
      if (sample_strobe) begin
        cnt     <= '0;
        col_idx <= (col_idx == LAST_COL) ? '0 : col_idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/key_matrix_scanner.sv
// Scans a ROWS x COLS button matrix, debounces full-matrix frames and emits single-key events.
module key_matrix_scanner
  import game_pkg::*;
#(
  parameter int COLS            = DEF_COLS,
  parameter int ROWS            = DEF_ROWS,
  parameter int SCAN_DIV        = 100_000,
  parameter int DEBOUNCE_FRAMES = 4
)(
  input  logic                 clk,
  input  logic                 reset,
  key_matrix_scanner_if.master bus
);
  localparam int NK = ROWS * COLS;
  localparam int KW = code_w(ROWS, COLS);
  localparam int IW = $clog2(COLS);
  localparam int SW = $clog2(DEBOUNCE_FRAMES);
  localparam int NW = $clog2(NK + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_FRAMES - 1);
  localparam logic [SW-1:0] STABLE_ACC = SW'(DEBOUNCE_FRAMES - 2);

  typedef logic [ROWS-1:0][COLS-1:0] mat_t;

  logic [IW-1:0]   col_idx;
  logic [COLS-1:0] col_drive;
  logic            sample_strobe, frame_end;

  scan_col_timer #(.COLS(COLS), .SCAN_DIV(SCAN_DIV)) u_timer (
    .clk           (clk),
    .reset         (reset),
    .col_idx       (col_idx),
    .col_drive     (col_drive),
    .sample_strobe (sample_strobe),
    .frame_end     (frame_end)
  );

  logic [ROWS-1:0] row_s1, row_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= bus.row_in;
      row_s2 <= row_s1;
    end
  end

  mat_t          snapshot, prev, debounced, snap_next;
  logic [SW-1:0] stable;
  logic          frame_eq;

  // Snapshot including the column being sampled this cycle, so frame_end
  // compares the complete frame.
  always_comb begin
    snap_next = snapshot;
    for (int r = 0; r < ROWS; r++) snap_next[r][col_idx] = ~row_s2[r];
  end

  assign frame_eq = (snap_next == prev);

  always_ff @(posedge clk) begin
    if (reset) begin
      snapshot  <= '0;
      prev      <= '0;
      debounced <= '0;
      stable    <= '0;
    end else if (sample_strobe) begin
      snapshot <= snap_next;
      if (frame_end) begin
        prev <= snap_next;
        if (frame_eq) begin
          if (stable != STABLE_MAX) stable <= stable + 1'b1;
          // Count reaching its top here means DEBOUNCE_FRAMES identical frames.
          if (stable >= STABLE_ACC) debounced <= snap_next;
        end else begin
          stable <= '0;
        end
      end
    end
  end

  logic [NK-1:0] deb_flat;
  logic [NW-1:0] n_keys;
  logic [KW-1:0] first_idx;

  assign deb_flat = debounced;

  always_comb begin
    n_keys    = '0;
    first_idx = '0;
    for (int k = NK - 1; k >= 0; k--) begin
      if (deb_flat[k]) begin
        n_keys    = n_keys + NW'(1);
        first_idx = KW'(k);
      end
    end
  end

  scan_state_t   state, state_n;
  logic [KW-1:0] key_code, code_n;
  logic          key_valid, valid_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      key_code  <= code_n;
      key_valid <= valid_n;
    end
  end

  // Events only leave IDLE; rollover and partial release out of MULTI stay silent.
  always_comb begin
    state_n = state;
    code_n  = key_code;
    valid_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (n_keys == NW'(1)) begin
          state_n = PRESSED;
          code_n  = first_idx;
          valid_n = 1'b1;
        end else if (n_keys >= NW'(2)) begin
          state_n = MULTI;
        end
      end
      PRESSED: begin
        if (n_keys == '0)           state_n = IDLE;
        else if (n_keys >= NW'(2))  state_n = MULTI;
      end
      MULTI: begin
        if (n_keys == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.col_drive = col_drive;
  assign bus.key_code  = key_code;
  assign bus.key_valid = key_valid;
  assign bus.key_held  = (state == PRESSED);
  assign bus.multi_key = (state == MULTI);
endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed plus randomized checks of the key matrix scanner against a settled-matrix event model.
module tb_key_matrix_scanner;
  import game_pkg::*;

  localparam int FRAME = 16;
  localparam int LAT   = 4 * FRAME + 3;
  localparam int SETTLE = 5 * FRAME;
  localparam int M_IDLE = 0, M_PRESSED = 1, M_MULTI = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  key_matrix_scanner_if #(.COLS(4), .ROWS(4)) bus ();

  key_matrix_scanner #(.COLS(4), .ROWS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Physical matrix: a closed switch pulls its row low while its column is strobed.
  logic [3:0][3:0] keys = '0;
  logic [3:0]      row_v;
  always_comb begin
    row_v = '1;
    for (int r = 0; r < 4; r++) row_v[r] = ~|(keys[r] & ~bus.col_drive);
  end
  assign bus.row_in = row_v;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  always @(negedge clk) begin
    if (!reset && bus.key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  // Event model over settled key sets.
  int m_state = M_IDLE;
  int m_code = 0;
  int exp_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int n, idx;
    n = 0; idx = 0;
    for (int r = 3; r >= 0; r--)
      for (int c = 3; c >= 0; c--)
        if (keys[r][c]) begin n++; idx = r * 4 + c; end
    case (m_state)
      M_IDLE: begin
        if (n == 1) begin m_state = M_PRESSED; m_code = idx; exp_pulses++; end
        else if (n >= 2) m_state = M_MULTI;
      end
      M_PRESSED: begin
        if (n == 0) m_state = M_IDLE;
        else if (n >= 2) m_state = M_MULTI;
      end
      default: if (n == 0) m_state = M_IDLE;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_held"},   bus.key_held,  m_state == M_PRESSED);
    chk({tag, "_multi"},  bus.multi_key, m_state == M_MULTI);
    chk({tag, "_code"},   bus.key_code,  m_code);
    chk({tag, "_pulses"}, pulse_cnt,     exp_pulses);
  endtask

  task automatic settle(input string tag);
    repeat (SETTLE) @(negedge clk);
    model_update();
    check_outputs(tag);
  endtask

  task automatic wait_pulse(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < LAT && !got; i++) begin
      @(negedge clk);
      if (bus.key_valid === 1'b1) got = 1'b1;
    end
    chk({tag, "_lat"}, got, 1);
    model_update();
    if (got) begin
      chk({tag, "_code"}, bus.key_code, m_code);
      chk({tag, "_held"}, bus.key_held, m_state == M_PRESSED);
      @(negedge clk);
      chk({tag, "_1cyc"}, bus.key_valid, 0);
    end
  endtask

  task automatic rand_gap();
    repeat ($urandom_range(0, 15)) @(negedge clk);
  endtask

  initial begin
    logic [3:0] pd;
    int run;
    bit first;
    int r, c;

    repeat (3) @(negedge clk);
    chk("rst_drive", bus.col_drive, 4'b1110);
    chk("rst_valid", bus.key_valid, 0);
    chk("rst_held",  bus.key_held,  0);
    chk("rst_multi", bus.multi_key, 0);
    chk("rst_code",  bus.key_code,  0);
    reset = 1'b0;

    // Idle scan: strobe rotates 0->1->2->3->0, 4 cycles per column after the first.
    pd = bus.col_drive; run = 0; first = 1'b1;
    repeat (100) begin
      @(negedge clk);
      run++;
      if (bus.col_drive !== pd) begin
        chk("col_seq", bus.col_drive, {pd[2:0], pd[3]});
        if (!first) chk("col_dwell", run, 4);
        first = 1'b0;
        pd = bus.col_drive;
        run = 0;
      end
    end
    chk("idle_pulses", pulse_cnt, 0);

    // Single steady press (row2,col1) and release.
    rand_gap();
    keys[2][1] = 1'b1;
    wait_pulse("k9");
    keys[2][1] = 1'b0;
    settle("k9_rel");

    // Bounce faster than a frame and off its period so no 3 frames agree.
    for (int i = 0; i < 13; i++) begin
      repeat (6) @(negedge clk);
      keys[0][0] = ~keys[0][0];
    end
    chk("bounce_pulses", pulse_cnt, exp_pulses);
    wait_pulse("k0");
    keys[0][0] = 1'b0;
    settle("k0_rel");

    // Two keys together, partial release, full release, then a fresh press.
    rand_gap();
    keys[1][1] = 1'b1; keys[3][2] = 1'b1;
    settle("multi");
    keys[3][2] = 1'b0;
    settle("multi_part");
    keys[1][1] = 1'b0;
    settle("multi_rel");
    keys[3][2] = 1'b1;
    wait_pulse("k14");
    keys[3][2] = 1'b0;
    settle("k14_rel");

    // Rollover from key 5 to key 6 without release.
    rand_gap();
    keys[1][1] = 1'b1;
    wait_pulse("k5");
    keys[1][1] = 1'b0; keys[1][2] = 1'b1;
    settle("roll");
    keys[1][2] = 1'b0;
    settle("roll_rel");

    // Reset while a press is still being debounced.
    r = $urandom_range(0, 3); c = $urandom_range(0, 3);
    keys[r][c] = 1'b1;
    repeat (20) @(negedge clk);
    chk("pre_rst_pulses", pulse_cnt, exp_pulses);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_drive", bus.col_drive, 4'b1110);
    chk("mid_rst_valid", bus.key_valid, 0);
    chk("mid_rst_held",  bus.key_held,  0);
    chk("mid_rst_multi", bus.multi_key, 0);
    chk("mid_rst_code",  bus.key_code,  0);
    m_state = M_IDLE; m_code = 0;
    reset = 1'b0;
    wait_pulse("post_rst");
    keys[r][c] = 1'b0;
    settle("post_rst_rel");

    // Random single keys.
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, 3); c = $urandom_range(0, 3);
      rand_gap();
      keys[r][c] = 1'b1;
      wait_pulse("rnd");
      keys[r][c] = 1'b0;
      settle("rnd_rel");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
